// File: rtl/sd_pkg.sv
// Shared constants and types for the SD card SPI-mode responder.
// Command indices, R1 flags, tokens, OCR values and FSM encodings.
package sd_pkg;

    localparam logic [5:0] CmdGoIdle     = 6'd0;
    localparam logic [5:0] CmdSendIfCond = 6'd8;
    localparam logic [5:0] CmdReadSingle = 6'd17;
    localparam logic [5:0] CmdSendOpCond = 6'd41;
    localparam logic [5:0] CmdAppCmd     = 6'd55;
    localparam logic [5:0] CmdReadOcr    = 6'd58;

    localparam logic [7:0] R1Ready      = 8'h00;
    localparam logic [7:0] R1Idle       = 8'h01;
    localparam logic [7:0] R1IllegalCmd = 8'h04;
    localparam logic [7:0] R1CrcErr     = 8'h08;

    localparam logic [7:0] DataToken = 8'hFE;
    localparam logic [7:0] FillByte  = 8'hFF;

    localparam logic [31:0] OcrReady = 32'hC0FF_8000;
    localparam logic [31:0] OcrBusy  = 32'h00FF_8000;

    localparam logic [8:0] LastByteIdx = 9'd511;

    typedef enum logic [2:0] {
        StHunt,
        StCmdRx,
        StNcr,
        StRespTx,
        StNac,
        StToken,
        StDataTx,
        StCrcTx
    } sd_state_e;

    // R1 flags with the idle bit derived from the card-ready state.
    function automatic logic [7:0] r1_with_idle(input logic [7:0] flags, input logic ready);
        return flags | {7'd0, ~ready};
    endfunction

endpackage

// File: rtl/sdr_edge_sync.sv
// Two-flop synchroniser with single-cycle rise and fall pulse outputs.
module sdr_edge_sync #(
    parameter logic ResetVal = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {3{ResetVal}};
        end else begin
            sync_q <= {sync_q[1:0], d_i};
        end
    end

    // sync_q[1] is the synchronised level; sync_q[2] is its previous value.
    assign rise_o = sync_q[1] & ~sync_q[2];
    assign fall_o = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/sd_spi_responder.sv
// SPI-mode SD card responder: CMD0/8/55/ACMD41/58 handling and CMD17 single-block reads
// served from an external byte memory, all running in the oversampling clock domain.
module sd_spi_responder
    import sd_pkg::*;
#(
    parameter int unsigned INIT_POLLS = 2,
    parameter int unsigned NCR_BYTES  = 1,
    parameter int unsigned NAC_BYTES  = 2
) (
    input  logic        sdr_clk_i,
    input  logic        sdr_rst_ni,
    input  logic        spi_sck_i,
    input  logic        spi_cs_ni,
    input  logic        spi_mosi_i,
    output logic        spi_miso_o,
    output logic [31:0] blk_addr_o,
    output logic        mem_rd_o,
    output logic [8:0]  mem_addr_o,
    input  logic [7:0]  mem_data_i,
    output logic        card_ready_o
);

    localparam logic [7:0] PollTarget = 8'(INIT_POLLS);
    localparam logic [7:0] NcrLast    = 8'(NCR_BYTES - 1);
    localparam logic [7:0] NacLast    = 8'(NAC_BYTES - 1);

    logic       sck_rise, sck_fall;
    logic [1:0] cs_sync_q, mosi_sync_q;
    logic       cs_n, mosi;

    sdr_edge_sync #(
        .ResetVal (1'b0)
    ) u_sck_sync (
        .clk_i  (sdr_clk_i),
        .rst_ni (sdr_rst_ni),
        .d_i    (spi_sck_i),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    always_ff @(posedge sdr_clk_i or negedge sdr_rst_ni) begin
        if (!sdr_rst_ni) begin
            cs_sync_q   <= 2'b11;
            mosi_sync_q <= 2'b11;
        end else begin
            cs_sync_q   <= {cs_sync_q[0], spi_cs_ni};
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi_i};
        end
    end

    assign cs_n = cs_sync_q[1];
    assign mosi = mosi_sync_q[1];

    sd_state_e   state_q, state_d;
    logic [47:0] cmd_q, cmd_d;
    logic [5:0]  rx_cnt_q, rx_cnt_d;
    logic [7:0]  sh_q, sh_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [39:0] resp_q, resp_d;
    logic [2:0]  resp_left_q, resp_left_d;
    logic [8:0]  data_cnt_q, data_cnt_d;
    logic        rd_pend_q, rd_pend_d;
    logic        miso_q, miso_d;
    logic        mem_rd_q, mem_rd_d;
    logic        rd_dly_q, rd_dly_d;
    logic [7:0]  rd_buf_q, rd_buf_d;
    logic [8:0]  mem_addr_q, mem_addr_d;
    logic [31:0] blk_addr_q, blk_addr_d;
    logic        ready_q, ready_d;
    logic [7:0]  poll_q, poll_d;
    logic        app_q, app_d;

    // Command decode, evaluated on the frame including the bit arriving this cycle.
    logic [47:0] frame;
    logic [5:0]  cmd_idx;
    logic [31:0] cmd_arg;
    logic [7:0]  dec_r1;
    logic [31:0] dec_tail;
    logic [2:0]  dec_len;
    logic        dec_ready, dec_app, dec_read;
    logic [7:0]  dec_poll;
    logic        unused_frame_bits;

    assign frame   = {cmd_q[46:0], mosi};
    assign cmd_idx = frame[45:40];
    assign cmd_arg = frame[39:8];
    // Start bits are guaranteed by the hunt logic and CRC7 is not checked in SPI mode.
    assign unused_frame_bits = ^{cmd_q[47], frame[47:46], frame[7:1]};

    always_comb begin
        dec_r1    = r1_with_idle(R1IllegalCmd, ready_q);
        dec_tail  = '1;
        dec_len   = 3'd1;
        dec_ready = ready_q;
        dec_poll  = poll_q;
        dec_app   = 1'b0;
        dec_read  = 1'b0;
        if (!frame[0]) begin
            dec_r1  = r1_with_idle(R1CrcErr, ready_q);
            dec_app = app_q;
        end else begin
            case (cmd_idx)
                CmdGoIdle: begin
                    dec_ready = 1'b0;
                    dec_poll  = '0;
                    dec_r1    = R1Idle;
                end
                CmdSendIfCond: begin
                    dec_r1   = r1_with_idle(R1Ready, ready_q);
                    dec_tail = {16'h0000, 4'h0, cmd_arg[11:8], cmd_arg[7:0]};
                    dec_len  = 3'd5;
                end
                CmdAppCmd: begin
                    dec_r1  = r1_with_idle(R1Ready, ready_q);
                    dec_app = 1'b1;
                end
                CmdSendOpCond: begin
                    if (app_q) begin
                        if (ready_q || poll_q == PollTarget) begin
                            dec_ready = 1'b1;
                            dec_r1    = R1Ready;
                        end else begin
                            dec_poll = poll_q + 8'd1;
                            dec_r1   = R1Idle;
                        end
                    end
                end
                CmdReadOcr: begin
                    dec_r1   = r1_with_idle(R1Ready, ready_q);
                    dec_tail = ready_q ? OcrReady : OcrBusy;
                    dec_len  = 3'd5;
                end
                CmdReadSingle: begin
                    if (ready_q) begin
                        dec_r1   = R1Ready;
                        dec_read = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    logic tx_active, byte_done;

    assign tx_active = !(state_q inside {StHunt, StCmdRx});
    assign byte_done = tx_active && sck_fall && (bit_q == 3'd7);

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        rx_cnt_d    = rx_cnt_q;
        sh_d        = sh_q;
        bit_d       = bit_q;
        cnt_d       = cnt_q;
        resp_d      = resp_q;
        resp_left_d = resp_left_q;
        data_cnt_d  = data_cnt_q;
        rd_pend_d   = rd_pend_q;
        miso_d      = miso_q;
        mem_rd_d    = 1'b0;
        rd_dly_d    = mem_rd_q;
        rd_buf_d    = rd_buf_q;
        mem_addr_d  = mem_addr_q;
        blk_addr_d  = blk_addr_q;
        ready_d     = ready_q;
        poll_d      = poll_q;
        app_d       = app_q;

        if (rd_dly_q) begin
            rd_buf_d = mem_data_i;
        end
        if (mem_rd_q && mem_addr_q != LastByteIdx) begin
            mem_addr_d = mem_addr_q + 9'd1;
        end

        if (cs_n) begin
            state_d   = StHunt;
            miso_d    = 1'b1;
            cmd_d     = '1;
            rx_cnt_d  = '0;
            sh_d      = '1;
            bit_d     = '0;
            rd_pend_d = 1'b0;
        end else begin
            if (sck_fall) begin
                if (tx_active) begin
                    miso_d = sh_q[7];
                    sh_d   = {sh_q[6:0], 1'b1};
                    bit_d  = bit_q + 3'd1;
                end else begin
                    miso_d = 1'b1;
                end
            end

            // Byte-boundary loads override the shift so the next fall emits the new MSB.
            unique case (state_q)
                StHunt: begin
                    if (sck_rise && !mosi) begin
                        cmd_d    = frame;
                        rx_cnt_d = 6'd1;
                        state_d  = StCmdRx;
                    end
                end
                StCmdRx: begin
                    if (sck_rise) begin
                        if (rx_cnt_q == 6'd47) begin
                            cmd_d     = '1;
                            rx_cnt_d  = '0;
                            ready_d   = dec_ready;
                            poll_d    = dec_poll;
                            app_d     = dec_app;
                            rd_pend_d = dec_read;
                            bit_d     = '0;
                            cnt_d     = '0;
                            if (dec_read) begin
                                blk_addr_d = cmd_arg;
                                mem_addr_d = '0;
                            end
                            if (NCR_BYTES == 0) begin
                                sh_d        = dec_r1;
                                resp_d      = {dec_tail, FillByte};
                                resp_left_d = dec_len - 3'd1;
                                state_d     = StRespTx;
                            end else begin
                                sh_d        = FillByte;
                                resp_d      = {dec_r1, dec_tail};
                                resp_left_d = dec_len;
                                state_d     = StNcr;
                            end
                        end else begin
                            cmd_d    = frame;
                            rx_cnt_d = rx_cnt_q + 6'd1;
                        end
                    end
                end
                StNcr: begin
                    if (byte_done) begin
                        if (cnt_q == NcrLast) begin
                            sh_d        = resp_q[39:32];
                            resp_d      = {resp_q[31:0], FillByte};
                            resp_left_d = resp_left_q - 3'd1;
                            state_d     = StRespTx;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                end
                StRespTx: begin
                    if (byte_done) begin
                        if (resp_left_q != 3'd0) begin
                            sh_d        = resp_q[39:32];
                            resp_d      = {resp_q[31:0], FillByte};
                            resp_left_d = resp_left_q - 3'd1;
                        end else if (rd_pend_q) begin
                            cnt_d = '0;
                            if (NAC_BYTES == 0) begin
                                sh_d     = DataToken;
                                mem_rd_d = 1'b1;
                                state_d  = StToken;
                            end else begin
                                sh_d    = FillByte;
                                state_d = StNac;
                            end
                        end else begin
                            state_d = StHunt;
                        end
                    end
                end
                StNac: begin
                    if (byte_done) begin
                        if (cnt_q == NacLast) begin
                            sh_d     = DataToken;
                            mem_rd_d = 1'b1;
                            state_d  = StToken;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                end
                StToken: begin
                    if (byte_done) begin
                        sh_d       = rd_buf_q;
                        data_cnt_d = '0;
                        mem_rd_d   = 1'b1;
                        state_d    = StDataTx;
                    end
                end
                StDataTx: begin
                    if (byte_done) begin
                        if (data_cnt_q == LastByteIdx) begin
                            sh_d      = FillByte;
                            cnt_d     = '0;
                            rd_pend_d = 1'b0;
                            state_d   = StCrcTx;
                        end else begin
                            sh_d       = rd_buf_q;
                            data_cnt_d = data_cnt_q + 9'd1;
                            // The byte just loaded is the last one; nothing left to prefetch.
                            mem_rd_d   = (data_cnt_q != LastByteIdx - 9'd1);
                        end
                    end
                end
                StCrcTx: begin
                    if (byte_done) begin
                        if (cnt_q == 8'd1) begin
                            state_d = StHunt;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge sdr_clk_i or negedge sdr_rst_ni) begin
        if (!sdr_rst_ni) begin
            state_q     <= StHunt;
            cmd_q       <= '1;
            rx_cnt_q    <= '0;
            sh_q        <= '1;
            bit_q       <= '0;
            cnt_q       <= '0;
            resp_q      <= '1;
            resp_left_q <= '0;
            data_cnt_q  <= '0;
            rd_pend_q   <= 1'b0;
            miso_q      <= 1'b1;
            mem_rd_q    <= 1'b0;
            rd_dly_q    <= 1'b0;
            rd_buf_q    <= '1;
            mem_addr_q  <= '0;
            blk_addr_q  <= '0;
            ready_q     <= 1'b0;
            poll_q      <= '0;
            app_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            rx_cnt_q    <= rx_cnt_d;
            sh_q        <= sh_d;
            bit_q       <= bit_d;
            cnt_q       <= cnt_d;
            resp_q      <= resp_d;
            resp_left_q <= resp_left_d;
            data_cnt_q  <= data_cnt_d;
            rd_pend_q   <= rd_pend_d;
            miso_q      <= miso_d;
            mem_rd_q    <= mem_rd_d;
            rd_dly_q    <= rd_dly_d;
            rd_buf_q    <= rd_buf_d;
            mem_addr_q  <= mem_addr_d;
            blk_addr_q  <= blk_addr_d;
            ready_q     <= ready_d;
            poll_q      <= poll_d;
            app_q       <= app_d;
        end
    end

    assign spi_miso_o   = miso_q;
    assign blk_addr_o   = blk_addr_q;
    assign mem_rd_o     = mem_rd_q;
    assign mem_addr_o   = mem_addr_q;
    assign card_ready_o = ready_q;

endmodule

// File: tb/tb_sd_spi_responder.sv
// Self-checking bench: SPI mode-0 host model, byte memory and expected-byte scoreboard.
module tb_sd_spi_responder;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        sck   = 1'b0;
    logic        cs_n  = 1'b1;
    logic        mosi  = 1'b1;
    logic        miso;
    logic [31:0] blk_addr;
    logic        mem_rd;
    logic [8:0]  mem_addr;
    logic [7:0]  mem_data = 8'h00;
    logic        ready;

    int checks = 0;
    int errors = 0;
    int rd_pulses = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    sd_spi_responder #(
        .INIT_POLLS (2),
        .NCR_BYTES  (1),
        .NAC_BYTES  (2)
    ) dut (
        .sdr_clk_i    (clk),
        .sdr_rst_ni   (rst_n),
        .spi_sck_i    (sck),
        .spi_cs_ni    (cs_n),
        .spi_mosi_i   (mosi),
        .spi_miso_o   (miso),
        .blk_addr_o   (blk_addr),
        .mem_rd_o     (mem_rd),
        .mem_addr_o   (mem_addr),
        .mem_data_i   (mem_data),
        .card_ready_o (ready)
    );

    // Block memory: byte i holds i[7:0], one cycle read latency.
    always @(posedge clk) if (mem_rd) mem_data <= mem_addr[7:0];
    always @(negedge clk) if (mem_rd) rd_pulses <= rd_pulses + 1;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Mode 0: data changes while SCK low, sampled by both sides on the rise.
    task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '1;
        for (int i = 7; i > 7 - nbits; i--) begin
            @(negedge clk);
            mosi = tx[i];
            repeat (4) @(negedge clk);
            rx[i] = miso;
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
        end
        mosi = 1'b1;
    endtask

    task automatic send_cmd(input logic [47:0] cmd);
        logic [7:0] rx;
        for (int b = 5; b >= 0; b--) xfer_bits(cmd[b*8 +: 8], 8, rx);
    endtask

    task automatic read_expected(input int n, input string tag);
        logic [7:0] rx;
        logic [7:0] exp;
        for (int k = 0; k < n; k++) begin
            xfer_bits(8'hFF, 8, rx);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s byte %0d: got %0h expected nothing queued", tag, k, rx);
            end else begin
                exp = exp_q.pop_front();
                check($sformatf("%s byte %0d", tag, k), {40'd0, rx}, {40'd0, exp});
            end
        end
    endtask

    task automatic run_cmd(input logic [47:0] cmd, input int n, input logic [47:0] exp,
                           input string tag);
        send_cmd(cmd);
        for (int k = 0; k < n; k++) exp_q.push_back(exp[47 - 8*k -: 8]);
        read_expected(n, tag);
    endtask

    typedef struct {
        logic [47:0] cmd;
        int          n;
        logic [47:0] exp;
        logic        rdy;
        string       tag;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [7:0] rx;
        int pulses_start;

        // Response bytes include the leading NCR 0xFF, left-aligned.
        vecs[0]  = '{48'h40_0000_0000_95, 2, 48'hFF01_0000_0000, 1'b0, "cmd0"};
        vecs[1]  = '{48'h48_0000_01AA_87, 6, 48'hFF01_0000_01AA, 1'b0, "cmd8 r7"};
        vecs[2]  = '{48'h51_0000_0010_01, 2, 48'hFF05_0000_0000, 1'b0, "cmd17 not ready"};
        vecs[3]  = '{48'h77_0000_0000_01, 2, 48'hFF01_0000_0000, 1'b0, "cmd55 a"};
        vecs[4]  = '{48'h69_0000_0000_01, 2, 48'hFF01_0000_0000, 1'b0, "acmd41 busy1"};
        vecs[5]  = '{48'h77_0000_0000_01, 2, 48'hFF01_0000_0000, 1'b0, "cmd55 b"};
        vecs[6]  = '{48'h69_0000_0000_01, 2, 48'hFF01_0000_0000, 1'b0, "acmd41 busy2"};
        vecs[7]  = '{48'h77_0000_0000_01, 2, 48'hFF01_0000_0000, 1'b0, "cmd55 c"};
        vecs[8]  = '{48'h69_0000_0000_01, 2, 48'hFF00_0000_0000, 1'b1, "acmd41 ready"};
        vecs[9]  = '{48'h7A_0000_0000_01, 6, 48'hFF00_C0FF_8000, 1'b1, "cmd58 r3"};
        vecs[10] = '{48'h7A_0000_0000_00, 2, 48'hFF08_0000_0000, 1'b1, "end bit 0"};
        vecs[11] = '{48'h69_0000_0000_01, 2, 48'hFF04_0000_0000, 1'b1, "acmd41 no app"};

        repeat (4) @(negedge clk);
        check("reset miso", {47'd0, miso}, 48'd1);
        check("reset ready", {47'd0, ready}, 48'd0);
        check("reset mem_rd", {47'd0, mem_rd}, 48'd0);
        check("reset mem_addr", {39'd0, mem_addr}, 48'd0);
        check("reset blk_addr", {16'd0, blk_addr}, 48'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);

        for (int v = 0; v < 12; v++) begin
            run_cmd(vecs[v].cmd, vecs[v].n, vecs[v].exp, vecs[v].tag);
            check({vecs[v].tag, " ready"}, {47'd0, ready}, {47'd0, vecs[v].rdy});
        end

        // Full block read from address 0x10.
        pulses_start = rd_pulses;
        send_cmd(48'h51_0000_0010_01);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFE);
        for (int i = 0; i < 512; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        read_expected(519, "cmd17 block");
        check("blk_addr", {16'd0, blk_addr}, 48'h10);
        check("mem_rd count", 48'(rd_pulses - pulses_start), 48'd512);
        check("mem_addr no wrap", {39'd0, mem_addr}, 48'd511);
        check("queue drained", 48'(exp_q.size()), 48'd0);

        // CS abort part-way through data byte 100, then a clean CMD58.
        send_cmd(48'h51_0000_0010_01);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFE);
        for (int i = 0; i < 100; i++) exp_q.push_back(8'(i));
        read_expected(105, "cmd17 abort");
        xfer_bits(8'hFF, 3, rx);
        cs_n = 1'b1;
        repeat (5) @(negedge clk);
        check("cs abort miso", {47'd0, miso}, 48'd1);
        check("cs abort ready kept", {47'd0, ready}, 48'd1);
        repeat (8) @(negedge clk);
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        run_cmd(48'h7A_0000_0000_01, 6, 48'hFF00_C0FF_8000, "cmd58 after abort");

        // Reset asserted in the middle of an R7.
        send_cmd(48'h48_0000_01AA_87);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        read_expected(3, "r7 before reset");
        xfer_bits(8'hFF, 4, rx);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("mid-r7 reset miso", {47'd0, miso}, 48'd1);
        check("mid-r7 reset ready", {47'd0, ready}, 48'd0);
        check("mid-r7 reset blk_addr", {16'd0, blk_addr}, 48'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        xfer_bits(8'hFF, 4, rx);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        read_expected(2, "after reset quiet");
        run_cmd(48'h40_0000_0000_95, 2, 48'hFF01_0000_0000, "cmd0 after reset");
        check("final ready", {47'd0, ready}, 48'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
